// File: rtl/bist_resp_checker.sv
// RAM BIST response checker: compares RAM read data with the march generator's expected byte,
// accumulates the run verdict in tst_out, and logs the first failing addresses in a FWFT FIFO.
module bist_resp_checker #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned LOG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cmp_valid,
    input  logic [ADDR_W-1:0] cmp_addr,
    input  logic [DATA_W-1:0] cmp_exp,
    input  logic [DATA_W-1:0] rd_dat,
    input  logic              cmp_first,
    input  logic              cmp_last,
    input  logic              log_rd,
    output logic              log_valid,
    output logic [ADDR_W-1:0] log_addr,
    output logic [DATA_W-1:0] log_syn,
    output logic              log_ovf,
    output logic [7:0]        tst_out
);

    localparam int unsigned OCC_W = $clog2(LOG_DEPTH) + 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               ffirst_q, ffirst_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [LOG_DEPTH-1:0] lv_q, lv_d;
    logic [ADDR_W-1:0]  la_q [LOG_DEPTH];
    logic [ADDR_W-1:0]  la_d [LOG_DEPTH];
    logic [DATA_W-1:0]  ls_q [LOG_DEPTH];
    logic [DATA_W-1:0]  ls_d [LOG_DEPTH];

    logic               mismatch;
    logic               run_cmp;
    logic               log_clr;
    logic               pop;
    logic               full;
    logic               push;
    logic [OCC_W-1:0]   push_idx;
    logic [DATA_W-1:0]  syndrome;

    assign syndrome = rd_dat ^ cmp_exp;
    assign mismatch = (rd_dat != cmp_exp);
    assign run_cmp  = (state_q == ST_RUN) && cmp_valid;
    assign log_clr  = start && (state_q != ST_RUN);
    assign pop      = log_rd && lv_q[0];
    assign full     = (occ_q == OCC_W'(LOG_DEPTH));
    // A pop on the same edge frees a slot, so a full log still accepts the new entry.
    assign push     = run_cmp && mismatch && (!full || pop);
    assign push_idx = occ_q - OCC_W'(pop);

    // State register and all status/log storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            ffirst_q <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            occ_q    <= '0;
            lv_q     <= '0;
            for (int unsigned i = 0; i < LOG_DEPTH; i++) begin
                la_q[i] <= '0;
                ls_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            ffirst_q <= ffirst_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            occ_q    <= occ_d;
            lv_q     <= lv_d;
            for (int unsigned i = 0; i < LOG_DEPTH; i++) begin
                la_q[i] <= la_d[i];
                ls_q[i] <= ls_d[i];
            end
        end
    end

    // Run sequencing and verdict accumulation.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        ffirst_d = ffirst_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    busy_d   = 1'b1;
                    pass_d   = 1'b0;
                    fail_d   = 1'b0;
                    ffirst_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            ST_RUN: begin
                if (cmp_valid && mismatch) begin
                    fail_d = 1'b1;
                    if (cmp_first) begin
                        ffirst_d = 1'b1;
                    end
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (cmp_valid && cmp_last) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    pass_d  = ~fail_d;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Fail log: shift-register FIFO with the head at entry 0; empty slots are held at zero.
    always_comb begin
        occ_d = occ_q;
        ovf_d = ovf_q;
        lv_d  = lv_q;
        la_d  = la_q;
        ls_d  = ls_q;
        if (log_clr) begin
            occ_d = '0;
            ovf_d = 1'b0;
            lv_d  = '0;
            for (int unsigned i = 0; i < LOG_DEPTH; i++) begin
                la_d[i] = '0;
                ls_d[i] = '0;
            end
        end else begin
            if (run_cmp && mismatch && full && !pop) begin
                ovf_d = 1'b1;
            end
            if (pop) begin
                for (int unsigned i = 0; i < LOG_DEPTH - 1; i++) begin
                    la_d[i] = la_q[i+1];
                    ls_d[i] = ls_q[i+1];
                end
                la_d[LOG_DEPTH-1] = '0;
                ls_d[LOG_DEPTH-1] = '0;
                lv_d = {1'b0, lv_q[LOG_DEPTH-1:1]};
            end
            if (push) begin
                for (int unsigned i = 0; i < LOG_DEPTH; i++) begin
                    if (OCC_W'(i) == push_idx) begin
                        la_d[i] = cmp_addr;
                        ls_d[i] = syndrome;
                        lv_d[i] = 1'b1;
                    end
                end
            end
            occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    assign tst_out   = {cnt_q, ffirst_q, fail_q, pass_q, busy_q};
    assign log_valid = lv_q[0];
    assign log_addr  = la_q[0];
    assign log_syn   = ls_q[0];
    assign log_ovf   = ovf_q;

endmodule
